// File: rtl/dmem_port_arbiter.sv
// Port B arbiter between the CPU load/store path and the RAS spill/fill engine.
// Define DMEM_ARB_STARVE_GUARD_EN to enable the RAS starvation guard.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic          cpu_mmio,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic [3:0]    cpu_wen,
    input  logic [2:0]    cpu_strctrl,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_hold,
    input  logic          ras_req,
    input  logic          ras_wr,
    input  logic [AW-1:0] ras_addr,
    input  logic [DW-1:0] ras_din,
    output logic          ras_ack,
    output logic          ras_rvalid,
    output logic [DW-1:0] ras_dout,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [3:0]    mem_wen,
    output logic [2:0]    mem_strctrl,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_RD,
        CPU_WR,
        RAS_RD,
        RAS_WR
    } owner_t;

    owner_t        owner_q;
    owner_t        owner_d;
    logic [DW-1:0] cpu_q;
    logic [DW-1:0] ras_q;
    logic          cpu_req;
    logic          force_grant;
    logic          grant_cpu;
    logic          grant_ras;

    assign cpu_req = (cpu_rd | cpu_wr) & ~cpu_mmio;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (ras_req & ~grant_ras) begin
            if (wait_cnt != CW'(STARVE_LIMIT))
                wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign force_grant = ras_req & (wait_cnt == CW'(STARVE_LIMIT));
`else
    logic unused_limit;

    assign unused_limit = ^STARVE_LIMIT;
    assign force_grant  = 1'b0;
`endif

    // Grants are gated by reset so the port goes quiet the moment rst rises.
    assign grant_ras = ~rst & ras_req & (force_grant | ~cpu_req);
    assign grant_cpu = ~rst & cpu_req & ~force_grant;
    assign ras_ack   = grant_ras;
    assign cpu_hold  = ~rst & force_grant & cpu_req;

    always_comb begin
        mem_en      = 1'b0;
        mem_addr    = cpu_addr;
        mem_din     = cpu_din;
        mem_wen     = 4'b0000;
        mem_strctrl = 3'b000;
        owner_d     = IDLE;
        unique case (1'b1)
            grant_ras: begin
                mem_en      = 1'b1;
                mem_addr    = ras_addr;
                mem_din     = ras_din;
                mem_wen     = ras_wr ? 4'b1111 : 4'b0000;
                mem_strctrl = ras_wr ? 3'b100 : 3'b000;
                owner_d     = ras_wr ? RAS_WR : RAS_RD;
            end
            grant_cpu: begin
                mem_en      = 1'b1;
                mem_wen     = cpu_wen;
                mem_strctrl = cpu_strctrl;
                owner_d     = cpu_wr ? CPU_WR : CPU_RD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= IDLE;
            cpu_q   <= '0;
            ras_q   <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == CPU_RD)
                cpu_q <= mem_dout;
            if (owner_q == RAS_RD)
                ras_q <= mem_dout;
        end
    end

    // Read data belongs to whoever held the port in the previous cycle.
    assign ras_rvalid = (owner_q == RAS_RD);
    assign ras_dout   = ras_rvalid ? mem_dout : ras_q;
    assign cpu_dout   = (owner_q == CPU_RD) ? mem_dout : cpu_q;

endmodule
